// File: rtl/program_loader.sv
// program_loader: byte-stream program loader driving unified memory port A.
// Accepts a length-prefixed little-endian byte stream, packs it into 32-bit
// words and stores them from word 0 upward while holding the CPU.
// Optional feature macro: LOADER_CHECKSUM_EN adds an XOR trailer check.
module program_loader #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  Start,
  input  logic [7:0]            Rx_Data,
  input  logic                  Rx_Valid,
  output logic                  Rx_Ready,
  output logic                  MEM_W_En,
  output logic [2:0]            MEM_Control,
  output logic [ADDR_WIDTH+1:0] RW_Addr,
  output logic [31:0]           W_Data,
  output logic                  CPU_Hold,
  output logic                  Done,
  output logic                  Error
);

  localparam logic [2:0]  MEM_WORD = 3'b010;
  localparam int unsigned CW       = ADDR_WIDTH + 1;
  localparam logic [16:0] MAX_LEN  = 17'd1 << ADDR_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_LO,
    S_LEN_HI,
    S_DATA,
    S_WRITE,
`ifdef LOADER_CHECKSUM_EN
    S_CHECK,
`endif
    S_DONE,
    S_ERR
  } state_t;

  state_t          state, state_n;
  logic [15:0]     len_q;
  logic [CW-1:0]   word_idx;
  logic [1:0]      byte_idx;
  logic            accept;
  logic [15:0]     len_full;
  logic            last_word;
  logic            ready_n, hold_n, done_n, err_n, wen_n;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]      checksum;
`endif

  assign MEM_Control = MEM_WORD;
  assign accept      = Rx_Valid && Rx_Ready;
  assign len_full    = {Rx_Data, len_q[7:0]};
  // Compared before the increment in a wide domain so len == 2**ADDR_WIDTH cannot wrap
  assign last_word   = (32'(word_idx) + 32'd1) == {16'd0, len_q};

  // Next-state selection
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE, S_DONE, S_ERR: begin
        if (Start) state_n = S_LEN_LO;
      end
      S_LEN_LO: begin
        if (accept) state_n = S_LEN_HI;
      end
      S_LEN_HI: begin
        if (accept) begin
          if ({1'b0, len_full} > MAX_LEN) begin
            state_n = S_ERR;
          end else if (len_full == 16'd0) begin
`ifdef LOADER_CHECKSUM_EN
            state_n = S_CHECK;
`else
            state_n = S_DONE;
`endif
          end else begin
            state_n = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (accept && byte_idx == 2'd3) state_n = S_WRITE;
      end
      S_WRITE: begin
        if (last_word) begin
`ifdef LOADER_CHECKSUM_EN
          state_n = S_CHECK;
`else
          state_n = S_DONE;
`endif
        end else begin
          state_n = S_DATA;
        end
      end
`ifdef LOADER_CHECKSUM_EN
      S_CHECK: begin
        if (accept) state_n = (Rx_Data == checksum) ? S_DONE : S_ERR;
      end
`endif
      default: state_n = S_IDLE;
    endcase
  end

  // Output levels for the upcoming state; registered below so they follow state exactly
  always_comb begin
    ready_n = 1'b0;
    hold_n  = 1'b1;
    done_n  = 1'b0;
    err_n   = 1'b0;
    wen_n   = 1'b0;
    case (state_n)
      S_IDLE:   hold_n = 1'b0;
      S_LEN_LO: ready_n = 1'b1;
      S_LEN_HI: ready_n = 1'b1;
      S_DATA:   ready_n = 1'b1;
      S_WRITE:  wen_n = 1'b1;
`ifdef LOADER_CHECKSUM_EN
      S_CHECK:  ready_n = 1'b1;
`endif
      S_DONE: begin
        hold_n = 1'b0;
        done_n = 1'b1;
      end
      S_ERR:    err_n = 1'b1;
      default:  hold_n = 1'b0;
    endcase
  end

  // State register and registered control outputs
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= S_IDLE;
      Rx_Ready <= 1'b0;
      CPU_Hold <= 1'b0;
      Done     <= 1'b0;
      Error    <= 1'b0;
      MEM_W_En <= 1'b0;
    end else begin
      state    <= state_n;
      Rx_Ready <= ready_n;
      CPU_Hold <= hold_n;
      Done     <= done_n;
      Error    <= err_n;
      MEM_W_En <= wen_n;
    end
  end

  // Datapath: length capture, word assembly, store address and indices
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      len_q    <= '0;
      word_idx <= '0;
      byte_idx <= '0;
      RW_Addr  <= '0;
      W_Data   <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE, S_ERR: begin
          if (Start) begin
            word_idx <= '0;
            byte_idx <= '0;
          end
        end
        S_LEN_LO: begin
          if (accept) len_q[7:0] <= Rx_Data;
        end
        S_LEN_HI: begin
          if (accept) len_q[15:8] <= Rx_Data;
        end
        S_DATA: begin
          if (accept) begin
            W_Data[8*byte_idx +: 8] <= Rx_Data;
            byte_idx <= byte_idx + 2'd1;
            // Address is set as the 4th byte lands so it is valid throughout WRITE
            if (byte_idx == 2'd3) RW_Addr <= {word_idx[ADDR_WIDTH-1:0], 2'b00};
          end
        end
        S_WRITE: begin
          word_idx <= word_idx + 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

`ifdef LOADER_CHECKSUM_EN
  // Running XOR of payload bytes only (length bytes excluded)
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      checksum <= '0;
    end else if ((state == S_IDLE || state == S_DONE || state == S_ERR) && Start) begin
      checksum <= '0;
    end else if (state == S_DATA && accept) begin
      checksum <= checksum ^ Rx_Data;
    end
  end
`endif

endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: randomized self-checking bench for program_loader.
// Expected stores come from the word list of each image: word i at byte
// address 4*i, little-endian packing. Honours LOADER_CHECKSUM_EN.
module tb_program_loader;

  localparam int AW = 10;

  typedef logic [31:0] wq_t[$];
  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [2:0]  ctl;
  } store_t;

  logic          CLK = 1'b0;
  logic          RST;
  logic          Start;
  logic [7:0]    Rx_Data;
  logic          Rx_Valid;
  logic          Rx_Ready;
  logic          MEM_W_En;
  logic [2:0]    MEM_Control;
  logic [AW+1:0] RW_Addr;
  logic [31:0]   W_Data;
  logic          CPU_Hold;
  logic          Done;
  logic          Error;

  int compared   = 0;
  int mismatched = 0;
  store_t seen[$];

  program_loader #(.ADDR_WIDTH(AW)) dut (
    .CLK(CLK), .RST(RST), .Start(Start), .Rx_Data(Rx_Data), .Rx_Valid(Rx_Valid),
    .Rx_Ready(Rx_Ready), .MEM_W_En(MEM_W_En), .MEM_Control(MEM_Control),
    .RW_Addr(RW_Addr), .W_Data(W_Data), .CPU_Hold(CPU_Hold), .Done(Done), .Error(Error)
  );

  always #5 CLK = ~CLK;

  // Record every store strobe seen mid-cycle
  always @(negedge CLK) begin
    if (MEM_W_En === 1'b1) seen.push_back('{32'(RW_Addr), W_Data, MEM_Control});
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic pulse_start();
    @(negedge CLK) Start = 1'b1;
    @(negedge CLK) Start = 1'b0;
  endtask

  // Present one byte after a random idle gap; returns at the negedge after the transfer
  task automatic send_byte(input logic [7:0] b, input int unsigned max_gap);
    int unsigned gap;
    int unsigned n;
    gap = (max_gap != 0) ? $urandom_range(max_gap, 0) : 0;
    repeat (gap) begin
      Rx_Data = 8'($urandom);
      @(negedge CLK);
    end
    Rx_Data  = b;
    Rx_Valid = 1'b1;
    n = 0;
    while (Rx_Ready !== 1'b1 && n < 64) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 64) begin
      compared++;
      mismatched++;
      $display("FAIL send_byte_timeout: Rx_Ready=%b required 1 within 64 cycles", Rx_Ready);
    end else begin
      @(negedge CLK);
    end
    Rx_Valid = 1'b0;
    Rx_Data  = 8'($urandom);
  endtask

  task automatic load(input wq_t words, input int unsigned max_gap);
    int unsigned len;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0] cs;
    cs = 8'h00;
`endif
    len = words.size();
    pulse_start();
    send_byte(len[7:0], max_gap);
    send_byte(len[15:8], max_gap);
    foreach (words[i]) begin
      for (int k = 0; k < 4; k++) begin
`ifdef LOADER_CHECKSUM_EN
        cs = cs ^ words[i][8*k +: 8];
`endif
        send_byte(words[i][8*k +: 8], max_gap);
      end
    end
`ifdef LOADER_CHECKSUM_EN
    send_byte(cs, max_gap);
`endif
  endtask

  // Bounded wait for a terminal level
  task automatic wait_end();
    int unsigned n;
    n = 0;
    while (!(Done === 1'b1 || Error === 1'b1) && n < 100) begin
      @(negedge CLK);
      n++;
    end
    @(negedge CLK);
  endtask

  task automatic test_reset();
    RST = 1'b1; Start = 1'b0; Rx_Valid = 1'b0; Rx_Data = 8'h00;
    repeat (3) @(negedge CLK);
    compared++;
    if ({Rx_Ready, MEM_W_En, CPU_Hold, Done, Error} !== 5'b0 || RW_Addr !== '0 || W_Data !== '0) begin
      mismatched++;
      $display("FAIL reset_outputs: rdy/wen/hold/done/err=%b addr=%h data=%h required all 0",
               {Rx_Ready, MEM_W_En, CPU_Hold, Done, Error}, RW_Addr, W_Data);
    end
    RST = 1'b0;
    repeat (2) @(negedge CLK);
    compared++;
    if ({Rx_Ready, CPU_Hold, Done, Error} !== 4'b0 || MEM_Control !== 3'b010) begin
      mismatched++;
      $display("FAIL idle_levels: rdy/hold/done/err=%b ctl=%b required 0000 / 010",
               {Rx_Ready, CPU_Hold, Done, Error}, MEM_Control);
    end
  endtask

  task automatic test_single_word();
    logic [7:0] bytes[6];
    bytes = '{8'h01, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00};
    seen.delete();
    pulse_start();
    compared++;
    if (CPU_Hold !== 1'b1 || Rx_Ready !== 1'b1) begin
      mismatched++;
      $display("FAIL single_hold: hold=%b rdy=%b required 1 1", CPU_Hold, Rx_Ready);
    end
    foreach (bytes[i]) send_byte(bytes[i], 0);
    compared++;
    if (MEM_W_En !== 1'b1 || RW_Addr !== '0 || W_Data !== 32'h13) begin
      mismatched++;
      $display("FAIL single_store: wen=%b addr=%h data=%h required 1 000 00000013", MEM_W_En, RW_Addr, W_Data);
    end
`ifdef LOADER_CHECKSUM_EN
    send_byte(8'h13, 0);
`else
    @(negedge CLK);
`endif
    compared++;
    if (MEM_W_En !== 1'b0 || Done !== 1'b1 || CPU_Hold !== 1'b0 || Error !== 1'b0) begin
      mismatched++;
      $display("FAIL single_done: wen=%b done=%b hold=%b err=%b required 0 1 0 0", MEM_W_En, Done, CPU_Hold, Error);
    end
    @(negedge CLK);
    compared++;
    if (seen.size() != 1) begin
      mismatched++;
      $display("FAIL single_count: stores=%0d required 1", seen.size());
    end
  endtask

  task automatic test_random_stall();
    wq_t w;
    for (int t = 0; t < 4; t++) begin
      w.delete();
      if (t == 0) w = '{32'h11223344, 32'h55667788, 32'h99AABBCC};
      else for (int i = 0; i < int'($urandom_range(6, 1)); i++) w.push_back($urandom);
      seen.delete();
      load(w, 3);
      wait_end();
      compared++;
      if (Done !== 1'b1 || Error !== 1'b0 || CPU_Hold !== 1'b0) begin
        mismatched++;
        $display("FAIL stall_done[%0d]: done=%b err=%b hold=%b required 1 0 0", t, Done, Error, CPU_Hold);
      end
      compared++;
      if (seen.size() != w.size()) begin
        mismatched++;
        $display("FAIL stall_count[%0d]: stores=%0d required %0d", t, seen.size(), w.size());
      end
      foreach (w[i]) if (i < seen.size()) begin
        compared++;
        if (seen[i].addr !== 32'(i * 4) || seen[i].data !== w[i] || seen[i].ctl !== 3'b010) begin
          mismatched++;
          $display("FAIL stall_store[%0d][%0d]: addr=%h data=%h ctl=%b required %h %h 010",
                   t, i, seen[i].addr, seen[i].data, seen[i].ctl, i * 4, w[i]);
        end
      end
    end
  endtask

  task automatic test_overflow();
    seen.delete();
    pulse_start();
    send_byte(8'h01, 0);
    send_byte(8'h04, 0);
    compared++;
    if (Error !== 1'b1 || CPU_Hold !== 1'b1 || Done !== 1'b0 || Rx_Ready !== 1'b0) begin
      mismatched++;
      $display("FAIL overflow_err: err=%b hold=%b done=%b rdy=%b required 1 1 0 0", Error, CPU_Hold, Done, Rx_Ready);
    end
    Rx_Valid = 1'b1;
    Rx_Data  = 8'hA5;
    repeat (6) @(negedge CLK);
    Rx_Valid = 1'b0;
    compared++;
    if (seen.size() != 0 || Rx_Ready !== 1'b0 || Error !== 1'b1) begin
      mismatched++;
      $display("FAIL overflow_quiet: stores=%0d rdy=%b err=%b required 0 0 1", seen.size(), Rx_Ready, Error);
    end
  endtask

  task automatic test_max_len();
    wq_t w;
    for (int i = 0; i < (1 << AW); i++) w.push_back($urandom);
    seen.delete();
    load(w, 0);
    wait_end();
    compared++;
    if (Done !== 1'b1 || Error !== 1'b0 || seen.size() != (1 << AW)) begin
      mismatched++;
      $display("FAIL maxlen_done: done=%b err=%b stores=%0d required 1 0 %0d", Done, Error, seen.size(), 1 << AW);
    end
    foreach (w[i]) if (i < seen.size()) begin
      compared++;
      if (seen[i].addr !== 32'(i * 4) || seen[i].data !== w[i]) begin
        mismatched++;
        $display("FAIL maxlen_store[%0d]: addr=%h data=%h required %h %h", i, seen[i].addr, seen[i].data, i * 4, w[i]);
      end
    end
  endtask

`ifdef LOADER_CHECKSUM_EN
  task automatic test_checksum();
    logic [7:0] bytes[6];
    logic [7:0] trailers[2];
    bytes    = '{8'h01, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00};
    trailers = '{8'h13, 8'h12};
    foreach (trailers[t]) begin
      seen.delete();
      pulse_start();
      foreach (bytes[i]) send_byte(bytes[i], 1);
      send_byte(trailers[t], 1);
      compared++;
      if (Done !== (t == 0) || Error !== (t != 0)) begin
        mismatched++;
        $display("FAIL checksum_result[%0d]: done=%b err=%b required %b %b", t, Done, Error, t == 0, t != 0);
      end
      compared++;
      if (seen.size() != 1 || seen[0].addr !== 32'h0 || seen[0].data !== 32'h13) begin
        mismatched++;
        $display("FAIL checksum_store[%0d]: stores=%0d required 1 store of 00000013 at 0", t, seen.size());
      end
    end
  endtask
`endif

  task automatic test_rst_mid();
    wq_t w;
    logic [7:0] hdr[6];
    hdr = '{8'h02, 8'h00, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    seen.delete();
    pulse_start();
    foreach (hdr[i]) send_byte(hdr[i], 1);
    @(negedge CLK);
    RST = 1'b1;
    #1;
    compared++;
    if ({Rx_Ready, MEM_W_En, CPU_Hold, Done, Error} !== 5'b0 || RW_Addr !== '0 || W_Data !== '0) begin
      mismatched++;
      $display("FAIL rst_mid_outputs: rdy/wen/hold/done/err=%b addr=%h data=%h required all 0",
               {Rx_Ready, MEM_W_En, CPU_Hold, Done, Error}, RW_Addr, W_Data);
    end
    @(negedge CLK);
    RST = 1'b0;
    compared++;
    if (seen.size() != 1 || seen[0].data !== 32'hEFBEADDE) begin
      mismatched++;
      $display("FAIL rst_mid_first: stores=%0d required 1 of EFBEADDE", seen.size());
    end
    w = '{$urandom, $urandom};
    seen.delete();
    load(w, 2);
    wait_end();
    compared++;
    if (Done !== 1'b1 || seen.size() != 2) begin
      mismatched++;
      $display("FAIL rst_reload_done: done=%b stores=%0d required 1 2", Done, seen.size());
    end
    foreach (w[i]) if (i < seen.size()) begin
      compared++;
      if (seen[i].addr !== 32'(i * 4) || seen[i].data !== w[i]) begin
        mismatched++;
        $display("FAIL rst_reload_store[%0d]: addr=%h data=%h required %h %h", i, seen[i].addr, seen[i].data, i * 4, w[i]);
      end
    end
  endtask

  task automatic test_len0_start_ignored();
    wq_t w;
    seen.delete();
    load(w, 0);
    wait_end();
    compared++;
    if (Done !== 1'b1 || Error !== 1'b0 || seen.size() != 0) begin
      mismatched++;
      $display("FAIL len0: done=%b err=%b stores=%0d required 1 0 0", Done, Error, seen.size());
    end
    w = '{$urandom, $urandom};
    seen.delete();
    pulse_start();
    send_byte(8'h02, 0);
    send_byte(8'h00, 0);
    send_byte(w[0][7:0], 0);
    send_byte(w[0][15:8], 0);
    pulse_start();
    send_byte(w[0][23:16], 0);
    send_byte(w[0][31:24], 0);
    for (int k = 0; k < 4; k++) send_byte(w[1][8*k +: 8], 1);
`ifdef LOADER_CHECKSUM_EN
    send_byte(w[0][7:0] ^ w[0][15:8] ^ w[0][23:16] ^ w[0][31:24] ^
              w[1][7:0] ^ w[1][15:8] ^ w[1][23:16] ^ w[1][31:24], 0);
`endif
    wait_end();
    compared++;
    if (Done !== 1'b1 || seen.size() != 2) begin
      mismatched++;
      $display("FAIL start_ignored_done: done=%b stores=%0d required 1 2", Done, seen.size());
    end
    foreach (w[i]) if (i < seen.size()) begin
      compared++;
      if (seen[i].addr !== 32'(i * 4) || seen[i].data !== w[i]) begin
        mismatched++;
        $display("FAIL start_ignored_store[%0d]: addr=%h data=%h required %h %h", i, seen[i].addr, seen[i].data, i * 4, w[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_random_stall();
    test_overflow();
    test_max_len();
`ifdef LOADER_CHECKSUM_EN
    test_checksum();
`endif
    test_rst_mid();
    test_len0_start_ignored();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
